// File: rtl/seq_pkg.sv
// Shared codes and helpers for the tank move sequencer.
// Combinational helpers only, so there is no latency and no backpressure.
// Holds mode/direction codes, the FSM state enum, the slot enum and slot-search helpers.
package seq_pkg;

  localparam logic [3:0] MODE_IDLE = 4'b0000;
  localparam logic [3:0] MODE_T1   = 4'b0001;
  localparam logic [3:0] MODE_P1   = 4'b0011;
  localparam logic [3:0] MODE_T2   = 4'b0101;
  localparam logic [3:0] MODE_P2   = 4'b0111;

  localparam logic [7:0] DIR_UP    = 8'h00;
  localparam logic [7:0] DIR_DOWN  = 8'h01;
  localparam logic [7:0] DIR_LEFT  = 8'h03;
  localparam logic [7:0] DIR_RIGHT = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SLOT_PREP   = 2'd1,
    ST_SLOT_COMMIT = 2'd2,
    ST_DONE        = 2'd3
  } state_t;

  // Enum order is the service order within a frame.
  typedef enum logic [1:0] {
    SLOT_T1 = 2'd0,
    SLOT_P1 = 2'd1,
    SLOT_T2 = 2'd2,
    SLOT_P2 = 2'd3
  } slot_t;

  function automatic logic dir_valid(input logic [7:0] d);
    return (d == DIR_UP) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction

  function automatic logic [3:0] slot_mode(input logic [1:0] s);
    logic [3:0] m;
    case (s)
      2'd0:    m = MODE_T1;
      2'd1:    m = MODE_P1;
      2'd2:    m = MODE_T2;
      default: m = MODE_P2;
    endcase
    return m;
  endfunction

  // Lowest active slot at or after start_idx; bit 2 of the result flags "found".
  function automatic logic [2:0] next_slot(input logic [3:0] mask, input logic [2:0] start_idx);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= start_idx)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [7:0] sel_dir(input logic [1:0] s, input logic [7:0] d0,
                                         input logic [7:0] d1, input logic [7:0] d2,
                                         input logic [7:0] d3);
    logic [7:0] d;
    case (s)
      2'd0:    d = d0;
      2'd1:    d = d1;
      2'd2:    d = d2;
      default: d = d3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Request and storage-control bundle between the game logic and the move sequencer.
// Pure wiring, no latency; strobes are fire-and-forget, no ready/backpressure path.
// Wall-write signals exist only when SEQ_WALL_WRITE_EN is defined.
interface move_sequencer_if;
  logic       tick;
  logic       t1_move_valid;
  logic [7:0] t1_move_dir;
  logic       t1_fire;
  logic       t2_move_valid;
  logic [7:0] t2_move_dir;
  logic       t2_fire;
  logic [3:0] mode;
  logic       wren;
  logic       load_out;
  logic [7:0] data;
  logic       busy;
  logic       frame_done;
  logic       tick_overrun;
`ifdef SEQ_WALL_WRITE_EN
  logic       wall_wr_valid;
  logic [7:0] wall_addr;
  logic [7:0] wall_data;
  logic [7:0] address;

  modport master (
    output tick, t1_move_valid, t1_move_dir, t1_fire, t2_move_valid, t2_move_dir, t2_fire,
    output wall_wr_valid, wall_addr, wall_data,
    input  mode, wren, load_out, data, busy, frame_done, tick_overrun, address
  );
  modport slave (
    input  tick, t1_move_valid, t1_move_dir, t1_fire, t2_move_valid, t2_move_dir, t2_fire,
    input  wall_wr_valid, wall_addr, wall_data,
    output mode, wren, load_out, data, busy, frame_done, tick_overrun, address
  );
`else
  modport master (
    output tick, t1_move_valid, t1_move_dir, t1_fire, t2_move_valid, t2_move_dir, t2_fire,
    input  mode, wren, load_out, data, busy, frame_done, tick_overrun
  );
  modport slave (
    input  tick, t1_move_valid, t1_move_dir, t1_fire, t2_move_valid, t2_move_dir, t2_fire,
    output mode, wren, load_out, data, busy, frame_done, tick_overrun
  );
`endif
endinterface

// File: rtl/req_latch.sv
// Sticky per-tank move/fire request holder, consumed by a frame-start snapshot.
// Requests are visible one cycle after their strobe; snapshot clears at the same edge.
// No backpressure: a later move overwrites the held direction, invalid codes are dropped.
module req_latch
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_move_vld,
  input  logic [7:0] i_move_dir,
  input  logic       i_fire,
  input  logic       i_snap,
  output logic       o_move_pend,
  output logic [7:0] o_move_dir,
  output logic       o_fire_pend
);

  logic       r_move_pend;
  logic [7:0] r_move_dir;
  logic       r_fire_pend;
  logic       w_move_ok;

  assign w_move_ok = i_move_vld && dir_valid(i_move_dir);

  // Clear on snapshot, but a strobe landing on the snapshot edge belongs to the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_move_pend <= 1'b0;
      r_move_dir  <= DIR_UP;
      r_fire_pend <= 1'b0;
    end else begin
      if (i_snap) begin
        r_move_pend <= 1'b0;
        r_fire_pend <= 1'b0;
      end
      if (w_move_ok) begin
        r_move_pend <= 1'b1;
        r_move_dir  <= i_move_dir;
      end
      if (i_fire) r_fire_pend <= 1'b1;
    end
  end

  assign o_move_pend = r_move_pend;
  assign o_move_dir  = r_move_dir;
  assign o_fire_pend = r_fire_pend;

endmodule

// File: rtl/move_sequencer.sv
// Per-tick frame sequencer: serves T1, P1, T2, P2 slots (PREP then COMMIT) into shared storage.
// First PREP appears the cycle after the tick; frame = 2 cycles per active slot + 1 DONE cycle.
// One tick is queued while busy, further ones are dropped with tick_overrun; SEQ_WALL_WRITE_EN adds wall writes.
module move_sequencer
  import seq_pkg::*;
#(
  parameter int PROJ_RANGE = 15
) (
  input logic             clk,
  input logic             reset,
  move_sequencer_if.slave bus
);

  localparam int CW = $clog2(PROJ_RANGE + 1);

  state_t         r_state;
  slot_t          r_slot;
  logic [3:0]     r_act;
  logic [7:0]     r_t1_mdir, r_t2_mdir;
  logic [7:0]     r_t1_dir, r_t2_dir, r_p1_dir, r_p2_dir;
  logic [CW-1:0]  r_p1_cnt, r_p2_cnt;
  logic           r_tick_pend;
  logic [3:0]     r_mode;
  logic           r_wren, r_load, r_busy, r_fdone, r_ovr;
  logic [7:0]     r_data;
`ifdef SEQ_WALL_WRITE_EN
  logic           r_wall_pend;
  logic [7:0]     r_wall_addr, r_wall_data, r_address;
`endif

  logic           w_t1_move_pend, w_t1_fire_pend, w_t2_move_pend, w_t2_fire_pend;
  logic [7:0]     w_t1_move_dir, w_t2_move_dir;
  logic           w_start, w_p1_load, w_p2_load;
  logic [3:0]     w_start_mask;
  logic [2:0]     w_first, w_next;
  logic [7:0]     w_first_dir, w_next_dir;

  req_latch u_t1_latch (
    .clk        (clk),
    .reset      (reset),
    .i_move_vld (bus.t1_move_valid),
    .i_move_dir (bus.t1_move_dir),
    .i_fire     (bus.t1_fire),
    .i_snap     (w_start),
    .o_move_pend(w_t1_move_pend),
    .o_move_dir (w_t1_move_dir),
    .o_fire_pend(w_t1_fire_pend)
  );

  req_latch u_t2_latch (
    .clk        (clk),
    .reset      (reset),
    .i_move_vld (bus.t2_move_valid),
    .i_move_dir (bus.t2_move_dir),
    .i_fire     (bus.t2_fire),
    .i_snap     (w_start),
    .o_move_pend(w_t2_move_pend),
    .o_move_dir (w_t2_move_dir),
    .o_fire_pend(w_t2_fire_pend)
  );

  // Frame-start decisions: a fire only arms an idle projectile, which is then active this frame.
  always_comb begin
    w_start      = (r_state == ST_IDLE) && (bus.tick || r_tick_pend);
    w_p1_load    = w_t1_fire_pend && (r_p1_cnt == '0);
    w_p2_load    = w_t2_fire_pend && (r_p2_cnt == '0);
    w_start_mask = {(r_p2_cnt != '0) || w_p2_load, w_t2_move_pend,
                    (r_p1_cnt != '0) || w_p1_load, w_t1_move_pend};
    w_first      = next_slot(w_start_mask, 3'd0);
    w_first_dir  = sel_dir(w_first[1:0], w_t1_move_dir, w_p1_load ? r_t1_dir : r_p1_dir,
                           w_t2_move_dir, w_p2_load ? r_t2_dir : r_p2_dir);
    w_next       = next_slot(r_act, 3'(r_slot) + 3'd1);
    w_next_dir   = sel_dir(w_next[1:0], r_t1_mdir, r_p1_dir, r_t2_mdir, r_p2_dir);
  end

  // Frame FSM with registered storage-control outputs, tick queueing and slot side effects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_slot      <= SLOT_T1;
      r_act       <= 4'b0000;
      r_t1_mdir   <= DIR_UP;
      r_t2_mdir   <= DIR_UP;
      r_t1_dir    <= DIR_DOWN;
      r_t2_dir    <= DIR_UP;
      r_p1_dir    <= DIR_DOWN;
      r_p2_dir    <= DIR_UP;
      r_p1_cnt    <= '0;
      r_p2_cnt    <= '0;
      r_tick_pend <= 1'b0;
      r_mode      <= MODE_IDLE;
      r_wren      <= 1'b0;
      r_load      <= 1'b0;
      r_data      <= 8'h00;
      r_busy      <= 1'b0;
      r_fdone     <= 1'b0;
      r_ovr       <= 1'b0;
`ifdef SEQ_WALL_WRITE_EN
      r_wall_pend <= 1'b0;
      r_wall_addr <= 8'h00;
      r_wall_data <= 8'h00;
      r_address   <= 8'h00;
`endif
    end else begin
      r_fdone <= 1'b0;
      r_ovr   <= 1'b0;

      // A tick met in IDLE starts the frame; if one was already queued, the new one stays queued.
      if (r_state == ST_IDLE) begin
        if (w_start) r_tick_pend <= bus.tick && r_tick_pend;
      end else if (bus.tick) begin
        if (r_tick_pend) r_ovr <= 1'b1;
        else             r_tick_pend <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_mode <= MODE_IDLE;
          r_wren <= 1'b0;
          r_load <= 1'b0;
          if (w_start) begin
            r_act     <= w_start_mask;
            r_t1_mdir <= w_t1_move_dir;
            r_t2_mdir <= w_t2_move_dir;
            r_busy    <= 1'b1;
            if (w_p1_load) begin
              r_p1_cnt <= CW'(PROJ_RANGE);
              r_p1_dir <= r_t1_dir;
            end
            if (w_p2_load) begin
              r_p2_cnt <= CW'(PROJ_RANGE);
              r_p2_dir <= r_t2_dir;
            end
            if (w_first[2]) begin
              r_state <= ST_SLOT_PREP;
              r_slot  <= slot_t'(w_first[1:0]);
              r_mode  <= slot_mode(w_first[1:0]);
              r_wren  <= 1'b1;
              r_load  <= 1'b1;
              r_data  <= w_first_dir;
            end else begin
              r_state <= ST_DONE;
              r_fdone <= 1'b1;
            end
          end
`ifdef SEQ_WALL_WRITE_EN
          else if (r_wall_pend) begin
            r_wren      <= 1'b1;
            r_address   <= r_wall_addr;
            r_data      <= r_wall_data;
            r_wall_pend <= 1'b0;
          end
`endif
        end
        ST_SLOT_PREP: begin
          r_state <= ST_SLOT_COMMIT;
          r_wren  <= 1'b0;
          r_load  <= 1'b0;
        end
        ST_SLOT_COMMIT: begin
          case (r_slot)
            SLOT_T1: r_t1_dir <= r_t1_mdir;
            SLOT_P1: if (r_p1_cnt != '0) r_p1_cnt <= r_p1_cnt - CW'(1);
            SLOT_T2: r_t2_dir <= r_t2_mdir;
            default: if (r_p2_cnt != '0) r_p2_cnt <= r_p2_cnt - CW'(1);
          endcase
          if (w_next[2]) begin
            r_state <= ST_SLOT_PREP;
            r_slot  <= slot_t'(w_next[1:0]);
            r_mode  <= slot_mode(w_next[1:0]);
            r_wren  <= 1'b1;
            r_load  <= 1'b1;
            r_data  <= w_next_dir;
          end else begin
            r_state <= ST_DONE;
            r_mode  <= MODE_IDLE;
            r_fdone <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

`ifdef SEQ_WALL_WRITE_EN
      // Capture last so a fresh wall request survives the cycle that drains the previous one.
      if (bus.wall_wr_valid) begin
        r_wall_pend <= 1'b1;
        r_wall_addr <= bus.wall_addr;
        r_wall_data <= bus.wall_data;
      end
`endif
    end
  end

  assign bus.mode         = r_mode;
  assign bus.wren         = r_wren;
  assign bus.load_out     = r_load;
  assign bus.data         = r_data;
  assign bus.busy         = r_busy;
  assign bus.frame_done   = r_fdone;
  assign bus.tick_overrun = r_ovr;
`ifdef SEQ_WALL_WRITE_EN
  assign bus.address      = r_address;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench: a frame-level model predicts slot/done events, a negedge monitor checks them.
module tb_move_sequencer;
  import seq_pkg::*;

  localparam int R = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_sequencer_if bus ();

  move_sequencer #(.PROJ_RANGE(R)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic       done;
    logic [3:0] mode;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (frame granularity)
  bit         m_mv[2];
  logic [7:0] m_mdir[2];
  bit         m_fire[2];
  logic [7:0] m_tdir[2];
  logic [7:0] m_pdir[2];
  int         m_cnt[2];
  bit         m_tpend;
  int         m_left = 0;
  int         m_ovr_exp = 0;
  int         ovr_seen = 0;
  bit         mon_en = 1'b0;
  logic [3:0] last_mode = 4'h0;
  logic [7:0] last_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_dir(input logic [7:0] d);
    return d == 8'h00 || d == 8'h01 || d == 8'h03 || d == 8'h07;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      m_mv[t] = 0; m_mdir[t] = 8'h00; m_fire[t] = 0; m_cnt[t] = 0;
    end
    m_tdir[0] = 8'h01; m_tdir[1] = 8'h00;
    m_pdir[0] = 8'h01; m_pdir[1] = 8'h00;
    m_tpend = 0;
    m_left  = 0;
    q.delete();
  endtask

  task automatic push_evt(input logic done, input logic [3:0] mode, input logic [7:0] data);
    exp_t e;
    e.done = done; e.mode = mode; e.data = data;
    q.push_back(e);
  endtask

  // What one rising edge does, given the inputs held across it.
  task automatic model_edge(input bit tk, input bit v1, input logic [7:0] d1, input bit f1,
                            input bit v2, input logic [7:0] d2, input bit f2);
    bit idle, start;
    int waiting, n;
    idle = (m_left == 0);
    if (!idle) m_left--;
    waiting = int'(m_tpend) + int'(tk);
    start = 0;
    if (idle && waiting > 0) begin start = 1; waiting--; end
    if (waiting > 1) begin m_ovr_exp++; waiting = 1; end
    m_tpend = (waiting > 0);
    if (start) begin
      n = 0;
      for (int t = 0; t < 2; t++) begin
        if (m_fire[t] && m_cnt[t] == 0) begin m_cnt[t] = R; m_pdir[t] = m_tdir[t]; end
        m_fire[t] = 0;
      end
      for (int t = 0; t < 2; t++) begin
        if (m_mv[t]) begin
          push_evt(1'b0, (t == 0) ? 4'b0001 : 4'b0101, m_mdir[t]);
          m_tdir[t] = m_mdir[t]; m_mv[t] = 0; n++;
        end
        if (m_cnt[t] > 0) begin
          push_evt(1'b0, (t == 0) ? 4'b0011 : 4'b0111, m_pdir[t]);
          m_cnt[t]--; n++;
        end
      end
      push_evt(1'b1, 4'h0, 8'h00);
      m_left = 2 * n + 1;
    end
    if (v1 && legal_dir(d1)) begin m_mv[0] = 1; m_mdir[0] = d1; end
    if (v2 && legal_dir(d2)) begin m_mv[1] = 1; m_mdir[1] = d2; end
    if (f1) m_fire[0] = 1;
    if (f2) m_fire[1] = 1;
  endtask

  task automatic drive(input bit tk, input bit v1, input logic [7:0] d1, input bit f1,
                       input bit v2, input logic [7:0] d2, input bit f2, input bit rs);
    @(negedge clk);
    bus.tick = tk;
    bus.t1_move_valid = v1; bus.t1_move_dir = d1; bus.t1_fire = f1;
    bus.t2_move_valid = v2; bus.t2_move_dir = d2; bus.t2_fire = f2;
    reset = rs;
    @(posedge clk);
    if (rs) model_reset();
    else    model_edge(tk, v1, d1, f1, v2, d2, f2);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mode"}, bus.mode, 4'h0);
    chk({tag, "_wren"}, bus.wren, 1'b0);
    chk({tag, "_load_out"}, bus.load_out, 1'b0);
    chk({tag, "_data"}, bus.data, 8'h00);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_frame_done"}, bus.frame_done, 1'b0);
    chk({tag, "_tick_overrun"}, bus.tick_overrun, 1'b0);
  endtask

  function automatic logic [7:0] rand_dir();
    case ($urandom_range(0, 4))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h03;
      3:       return 8'h07;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: pops the model's expected events as the DUT presents them.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", bus.busy, m_left > 0);
      if (m_left == 0) chk("idle_mode", bus.mode, 4'h0);
`ifndef SEQ_WALL_WRITE_EN
      if (!bus.load_out) chk("wren_outside_prep", bus.wren, 1'b0);
`endif
      if (bus.load_out) begin
        if (q.size() == 0) begin
          chk("slot_unexpected", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("slot_order", e.done, 1'b0);
          chk("slot_mode", bus.mode, e.mode);
          chk("slot_data", bus.data, e.data);
          chk("slot_wren", bus.wren, 1'b1);
          last_mode = e.mode;
          last_data = e.data;
        end
      end else if (bus.frame_done) begin
        if (q.size() == 0) begin
          chk("done_unexpected", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("done_order", e.done, 1'b1);
          chk("done_mode", bus.mode, 4'h0);
        end
      end else if (bus.mode != 4'h0) begin
        chk("commit_mode", bus.mode, last_mode);
        chk("commit_data", bus.data, last_data);
      end
      if (bus.tick_overrun) ovr_seen++;
    end
  end

  initial begin
    bit tk, v1, f1, v2, f2, rs;
    logic [7:0] d1, d2;
    bus.tick = 0;
    bus.t1_move_valid = 0; bus.t1_move_dir = 8'h00; bus.t1_fire = 0;
    bus.t2_move_valid = 0; bus.t2_move_dir = 8'h00; bus.t2_fire = 0;
`ifdef SEQ_WALL_WRITE_EN
    bus.wall_wr_valid = 0; bus.wall_addr = 8'h00; bus.wall_data = 8'h00;
`endif
    reset = 1;
    model_reset();
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    #1;
    check_reset_outputs("reset");
    mon_en = 1;

    // T1 moves right: single T1 slot then DONE
    drive(0, 1, 8'h07, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(4);
    // T2 strobes up then left: latest wins
    drive(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 0, 1, 8'h03, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(4);
    // Illegal direction is ignored
    drive(0, 1, 8'h05, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(3);
    // T1 fires; refire while in flight is discarded; projectile gone on the third frame
    drive(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(4);
    drive(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(4);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(4);
    // Empty frame
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(3);
    // Three back-to-back ticks across a busy frame
    drive(0, 1, 8'h01, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(8);
    chk("overrun_once", ovr_seen, 1);
    // Reset during T1 commit aborts the frame
    drive(0, 1, 8'h03, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    idle_cycles(1);
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    #1;
    check_reset_outputs("midframe_reset");
    idle_cycles(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tk = ($urandom_range(0, 5) == 0);
      v1 = ($urandom_range(0, 4) == 0); d1 = rand_dir(); f1 = ($urandom_range(0, 9) == 0);
      v2 = ($urandom_range(0, 4) == 0); d2 = rand_dir(); f2 = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 799) == 0);
      drive(tk, v1, d1, f1, v2, d2, f2, rs);
    end

    for (int i = 0; i < 60 && (m_left != 0 || m_tpend); i++) idle_cycles(1);
    idle_cycles(2);
    chk("drain_busy", bus.busy, 1'b0);
    chk("queue_empty", q.size(), 0);
    chk("overrun_count", ovr_seen, m_ovr_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
